// File: rtl/ahb_lite_slave.sv
// ahb_lite_slave: AHB-Lite word-organised RAM completer with byte/halfword/word
// transfers, configurable wait states and the two-cycle ERROR response.
// Optional feature macro: AHB_SLV_RO_REGION_EN (upper quarter of memory is read-only).
module ahb_lite_slave #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [1:0]            htrans,
  input  logic                  hready_i,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hresp,
  output logic                  hready
);

  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned LANES  = DATA_WIDTH / 8;
  localparam int unsigned WCNT_W = 3;
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(4 * MEM_DEPTH);
`ifdef AHB_SLV_RO_REGION_EN
  localparam logic [ADDR_WIDTH:0] RO_LIMIT = (ADDR_WIDTH+1)'(4 * ((3 * MEM_DEPTH) / 4));
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                hready_d, hresp_d;
  logic [IDX_W-1:0]    word_q;
  logic [LANES-1:0]    be_q, be_d;
  logic                write_q;
  logic                accept, req_err;
  logic                size_err, align_err, range_err;
  logic                we, rd_active;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic unused_bits;
  assign unused_bits = ^{hburst, hprot, htrans[0]};

  // Address phase qualification and legality checks
  assign accept    = hsel & hready_i & htrans[1] & hready;
  assign size_err  = (hsize > 3'd2);
  assign align_err = ((hsize == 3'd1) && haddr[0]) ||
                     ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign range_err = ({1'b0, haddr} >= ADDR_LIMIT);
`ifdef AHB_SLV_RO_REGION_EN
  assign req_err   = size_err | align_err | range_err |
                     (hwrite & ({1'b0, haddr} >= RO_LIMIT));
`else
  assign req_err   = size_err | align_err | range_err;
`endif

  // Byte-lane enables for the accepted transfer
  always_comb begin
    be_d = '0;
    case (hsize)
      3'd0:    be_d[haddr[1:0]] = 1'b1;
      3'd1:    be_d = haddr[1] ? LANES'(4'b1100) : LANES'(4'b0011);
      default: be_d = '1;
    endcase
  end

  // State, wait counter and registered response outputs
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      hready  <= 1'b1;
      hresp   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      hready  <= hready_d;
      hresp   <= hresp_d;
    end
  end

  // Next-state decode; a new address phase is only taken while hready is high
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    hready_d = 1'b1;
    hresp_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) begin
          if (req_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            wcnt_d  = WCNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == '0) state_d = ST_DATA;
        else              wcnt_d  = wcnt_q - WCNT_W'(1);
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    hready_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    hresp_d  = (state_d == ST_ERR1) || (state_d == ST_ERR2);
  end

  // Capture address-phase attributes on acceptance
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      word_q  <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
    end else if (accept) begin
      word_q  <= haddr[IDX_W+1:2];
      be_q    <= be_d;
      write_q <= hwrite;
    end
  end

  assign we        = (state_q == ST_DATA) && write_q;
  assign rd_active = ((state_q == ST_WAIT) || (state_q == ST_DATA)) && !write_q;

  // RAM write on the edge that ends an OKAY write data phase
  always_ff @(posedge hclk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_q[i]) mem[word_q][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  // Full word returned during read data phases, zero otherwise
  assign hrdata = rd_active ? mem[word_q] : '0;

endmodule

// File: tb/tb_ahb_lite_slave.sv
// tb_ahb_lite_slave: randomized scoreboard bench for ahb_lite_slave; one instance
// with zero wait states and one with two wait states, exercised in turn.
module tb_ahb_lite_slave;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned NBYTES = 4 * DEPTH;
  localparam int          WS0    = 0;
  localparam int          WS1    = 2;
`ifdef AHB_SLV_RO_REGION_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        cur;
  logic        hsel0, hsel1;
  logic [31:0] hrdata0, hrdata1;
  logic        hresp0, hresp1, hready0, hready1;
  logic [31:0] s_rdata;
  logic        s_resp, s_ready;

  int   compared   = 0;
  int   mismatched = 0;
  bit   mon_en     = 1'b0;
  int   seen_w     = 0;
  exp_t expq[$];
  logic [7:0] mem_b [2][NBYTES];

  always #5 hclk = ~hclk;

  assign hsel0   = hsel & ~cur;
  assign hsel1   = hsel & cur;
  assign s_rdata = cur ? hrdata1 : hrdata0;
  assign s_resp  = cur ? hresp1  : hresp0;
  assign s_ready = cur ? hready1 : hready0;

  ahb_lite_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS0)) dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans), .hready_i(hready0),
    .hwdata(hwdata), .hrdata(hrdata0), .hresp(hresp0), .hready(hready0));

  ahb_lite_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS1)) dut1 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel1), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans), .hready_i(hready1),
    .hwdata(hwdata), .hrdata(hrdata1), .hresp(hresp1), .hready(hready1));

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (dut%0d, t=%0t)", name, act, req, cur, $time);
    end
  endfunction

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  // Reference model: legality rules and a byte-addressed memory image
  function automatic bit model_err(logic [31:0] a, logic [2:0] s, logic w);
    if (s > 3'd2) return 1'b1;
    if ((a & ((32'd1 << s) - 32'd1)) != 32'd0) return 1'b1;
    if (a >= NBYTES) return 1'b1;
    if (RO_EN && w && ((a / 4) >= (3 * DEPTH / 4))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_write(logic [31:0] a, logic [2:0] s, logic [31:0] wd);
    for (int i = 0; i < (1 << s); i++) begin
      int unsigned b = a + 32'(i);
      mem_b[cur][b] = wd[8*(b%4) +: 8];
    end
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    int unsigned base = a & ~32'd3;
    return {mem_b[cur][base+3], mem_b[cur][base+2], mem_b[cur][base+1], mem_b[cur][base]};
  endfunction

  // Wait for the edge that accepts the presented address phase
  task automatic wait_ready();
    int n = 0;
    @(negedge hclk);
    while (!s_ready) begin
      n++;
      if (n > 16) begin
        mismatched++;
        $display("FAIL ready_timeout: hready stuck low, want high within 16 cycles (dut%0d)", cur);
        finish_run();
      end
      @(negedge hclk);
    end
    @(posedge hclk);
    #1;
  endtask

  // Present one address phase; on acceptance push the expected data-phase response
  task automatic do_xfer(input logic sel, input logic [1:0] trans, input logic [31:0] a,
                         input logic w, input logic [2:0] s, input logic [31:0] wd);
    exp_t e;
    hsel   = sel;
    htrans = trans;
    haddr  = a;
    hwrite = w;
    hsize  = s;
    hburst = 3'($urandom);
    hprot  = 4'($urandom);
    wait_ready();
    hwdata = wd;
    if (sel && trans[1]) begin
      e.err   = model_err(a, s, w);
      e.waits = e.err ? 1 : (cur ? WS1 : WS0);
      e.rdata = '0;
      if (!e.err) begin
        if (w) model_write(a, s, wd);
        else   e.rdata = model_read(a);
      end
      expq.push_back(e);
    end
  endtask

  task automatic do_idle();
    do_xfer(1'b0, 2'd0, 32'($urandom), 1'b0, 3'd2, 32'($urandom));
  endtask

  function automatic logic [31:0] rand_addr(logic [2:0] s);
    logic [31:0] a;
    int unsigned r = $urandom_range(0, 19);
    if (r == 0)      a = 32'($urandom) | 32'(NBYTES);
    else if (r == 1) a = 32'(NBYTES) + 32'($urandom_range(0, 15));
    else if (r < 10) a = 32'($urandom_range(0, 63));
    else             a = 32'($urandom_range(0, NBYTES - 1));
    if (s <= 3'd2 && $urandom_range(0, 9) != 0) a = a & ~((32'd1 << s) - 32'd1);
    return a;
  endfunction

  // Directed cases, memory clear, then random traffic on the selected instance
  task automatic run_dut();
    do_idle();
    do_xfer(1'b1, 2'd2, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
    do_xfer(1'b1, 2'd2, 32'h10, 1'b0, 3'd2, 32'($urandom));
    do_xfer(1'b1, 2'd2, 32'h20, 1'b1, 3'd2, 32'h0);
    do_xfer(1'b1, 2'd2, 32'h22, 1'b1, 3'd0, 32'h00AA0000);
    do_xfer(1'b1, 2'd3, 32'h20, 1'b1, 3'd1, 32'h00001234);
    do_xfer(1'b1, 2'd2, 32'h20, 1'b0, 3'd2, 32'($urandom));
    do_xfer(1'b1, 2'd2, 32'h02, 1'b0, 3'd2, 32'($urandom));
    do_xfer(1'b1, 2'd2, 32'(NBYTES), 1'b0, 3'd2, 32'($urandom));
    do_xfer(1'b1, 2'd2, 32'h40, 1'b1, 3'd2, 32'hCAFE0040);
    do_xfer(1'b1, 2'd2, 32'h40, 1'b0, 3'd2, 32'($urandom));
    do_xfer(1'b1, 2'd2, 32'h300, 1'b0, 3'd2, 32'($urandom));
    do_xfer(1'b1, 2'd2, 32'h300, 1'b1, 3'd2, 32'h55);
    do_xfer(1'b1, 2'd2, 32'h300, 1'b0, 3'd2, 32'($urandom));
    do_xfer(1'b1, 2'd1, 32'h10, 1'b0, 3'd2, 32'($urandom));
    do_xfer(1'b0, 2'd2, 32'h10, 1'b1, 3'd2, 32'h0BADF00D);
    do_xfer(1'b1, 2'd2, 32'h10, 1'b0, 3'd3, 32'($urandom));
    do_xfer(1'b1, 2'd2, 32'h11, 1'b0, 3'd1, 32'($urandom));
    for (int w = 0; w < int'(DEPTH); w++) begin
      if (!RO_EN || w < int'(3 * DEPTH / 4)) do_xfer(1'b1, 2'd2, 32'(4 * w), 1'b1, 3'd2, 32'h0);
    end
    for (int n = 0; n < 300; n++) begin
      int unsigned k = $urandom_range(0, 9);
      if (k == 0) begin
        int unsigned v = $urandom_range(0, 2);
        if (v == 0)      do_xfer(1'b0, 2'd2, 32'h10, 1'b1, 3'd2, 32'($urandom));
        else if (v == 1) do_xfer(1'b1, 2'd1, 32'h10, 1'b1, 3'd2, 32'($urandom));
        else             do_xfer(1'b1, 2'd0, 32'h10, 1'b1, 3'd2, 32'($urandom));
      end else begin
        logic [2:0] s = ($urandom_range(0, 11) == 0) ? 3'(3 + $urandom_range(0, 4))
                                                      : 3'($urandom_range(0, 2));
        do_xfer(1'b1, 2'($urandom_range(2, 3)), rand_addr(s), 1'($urandom), s, 32'($urandom));
      end
    end
    do_idle();
    do_idle();
  endtask

  // Monitor: pops the scoreboard at the end of each data phase
  initial begin
    exp_t e;
    forever begin
      @(negedge hclk);
      if (mon_en) begin
        if (expq.size() == 0) begin
          chk("idle_hready", 32'(s_ready), 32'd1);
          chk("idle_hresp", 32'(s_resp), 32'd0);
          chk("idle_hrdata", s_rdata, 32'd0);
        end else begin
          e = expq[0];
          if (!s_ready) begin
            seen_w++;
            chk("wait_hresp", 32'(s_resp), 32'(e.err));
            chk("extra_wait", 32'(seen_w > e.waits), 32'd0);
            if (e.err) chk("err1_hrdata", s_rdata, 32'd0);
          end else begin
            chk("wait_count", 32'(seen_w), 32'(e.waits));
            chk("final_hresp", 32'(s_resp), 32'(e.err));
            chk("hrdata", s_rdata, e.rdata);
            void'(expq.pop_front());
            seen_w = 0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  initial begin
    logic [31:0] a_val;
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < int'(NBYTES); b++) mem_b[d][b] = 8'h00;
    cur    = 1'b0;
    hreset = 1'b1;
    hsel   = 1'b0;
    htrans = 2'd0;
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = 3'd2;
    hburst = 3'd0;
    hprot  = 4'd0;
    hwdata = '0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst_hready0", 32'(hready0), 32'd1);
    chk("rst_hresp0", 32'(hresp0), 32'd0);
    chk("rst_hrdata0", hrdata0, 32'd0);
    chk("rst_hready1", 32'(hready1), 32'd1);
    chk("rst_hresp1", 32'(hresp1), 32'd0);
    chk("rst_hrdata1", hrdata1, 32'd0);
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    mon_en = 1'b1;

    run_dut();
    cur = 1'b1;
    run_dut();

    // Reset during a write's wait state must drop the write
    a_val = 32'($urandom);
    do_xfer(1'b1, 2'd2, 32'h80, 1'b1, 3'd2, a_val);
    hsel   = 1'b1;
    htrans = 2'd2;
    haddr  = 32'h80;
    hwrite = 1'b1;
    hsize  = 3'd2;
    wait_ready();
    hwdata = ~a_val;
    hsel   = 1'b0;
    htrans = 2'd0;
    mon_en = 1'b0;
    expq.delete();
    seen_w = 0;
    hreset = 1'b1;
    @(negedge hclk);
    chk("midrst_hready", 32'(s_ready), 32'd1);
    chk("midrst_hresp", 32'(s_resp), 32'd0);
    chk("midrst_hrdata", s_rdata, 32'd0);
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    mon_en = 1'b1;
    do_idle();
    do_xfer(1'b1, 2'd2, 32'h80, 1'b0, 3'd2, 32'($urandom));
    do_idle();
    do_idle();
    chk("queue_drained", 32'(expq.size()), 32'd0);
    finish_run();
  end

endmodule

// File: doc/ahb_lite_slave.md
Name: ahb_lite_slave

Overview:
AHB-Lite memory slave. It is the completer at the far end of the AHB-Lite master VIP bench and is driven by the master through the shared AHB interface. It holds a word-organised RAM, supports byte, halfword and word transfers with byte-lane writes, and can insert wait states. It returns the two-cycle ERROR response for illegal accesses.

Parameters:
ADDR_WIDTH, 32, width of haddr.
DATA_WIDTH, 32, width of hwdata/hrdata (fixed 32; other values unsupported).
MEM_DEPTH, 256, number of 32-bit words; legal byte address range is 0 to 4*MEM_DEPTH-1.
WAIT_STATES, 0, hready-low cycles inserted at the start of every OKAY data phase (0..7).

Ports:
hclk  in  1  bus clock; all state on rising edge
hreset  in  1  asynchronous active-high reset
hsel  in  1  slave select
haddr  in  ADDR_WIDTH  transfer byte address
hwrite  in  1  1=write, 0=read
hsize  in  3  0=byte, 1=halfword, 2=word; >2 illegal
hburst  in  3  burst type; accepted, not used for decode
hprot  in  4  protection; accepted, ignored
htrans  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ
hready_i  in  1  bus-level HREADY (previous transfer complete)
hwdata  in  DATA_WIDTH  write data (data phase)
hrdata  out  DATA_WIDTH  read data (data phase)
hresp  out  1  0=OKAY, 1=ERROR
hready  out  1  HREADYOUT of this slave

Behaviour:
- Reset (asynchronous, active-high): hready=1, hresp=0, hrdata=0. Any pending data phase and wait counter are cleared. RAM contents are not reset (initialised to 0 at time zero). Reset mid-transfer drops that transfer without writing RAM.
- Address phase accepted on a rising edge when hsel & hready_i & htrans[1]. At that edge, register haddr, hwrite, hsize, and a valid flag.
- IDLE/BUSY, or hsel=0 with hready_i=1: no transfer; the next cycle is a zero-wait OKAY (hready=1, hresp=0).
- Error conditions, checked at acceptance:
  - hsize>2;
  - misaligned address: halfword with haddr[0]=1, or word with haddr[1:0]!=0;
  - address >= 4*MEM_DEPTH.
- ERROR response: cycle 1 hready=0, hresp=1; cycle 2 hready=1, hresp=1; then idle. No RAM write. hrdata=0 during ERROR.
- OKAY data phase:
  - WAIT_STATES cycles of hready=0, hresp=0, then one cycle hready=1.
  - hresp stays 0 throughout.
  - A new address phase presented in the final cycle is accepted (pipelined, back-to-back).
- Write: on the edge ending the data phase (hready=1), write hwdata into RAM word haddr[..:2] using byte enables:
  - byte: lane haddr[1:0];
  - halfword: lanes {1,0} or {3,2} by haddr[1];
  - word: all lanes.
  - Only enabled bytes change.
- Read:
  - hrdata is driven combinationally from RAM at the registered word address during the data phase.
  - The full 32-bit word is returned; the master selects lanes.
  - hrdata=0 outside read data phases.
  - A read immediately following a write to the same word returns the new data, because the write commits on the edge starting the read's data phase.
- Simultaneous events: hsel/htrans changes during a wait state are ignored. Acceptance requires hready_i=1, which the slave's own hready feeds in a single-slave system.
- hburst is not checked; bursts are handled as a sequence of single transfers. Crossing a 1 KB boundary is not checked.

Optional Feature:
AHB_SLV_RO_REGION_EN. When defined, the upper quarter of memory (word index >= 3*MEM_DEPTH/4) is read-only. A write accepted there returns the two-cycle ERROR response and leaves RAM unchanged; reads there behave normally. When undefined, the entire memory is read/write, with no extra logic.

Test Plan:
- Reset: assert hreset for 3 cycles -> hready=1, hresp=0, hrdata=0; deassert and issue IDLE -> OKAY, zero wait.
- Word write then read, WAIT_STATES=0: NONSEQ write 0x10 data 0xDEADBEEF, followed back-to-back by NONSEQ read 0x10 -> read data phase hrdata=0xDEADBEEF, hresp=0, no wait states.
- Byte/halfword lanes: word 0x20=0x00000000; byte write 0xAA at 0x22; halfword write 0x1234 at 0x20 -> word read 0x20 returns 0x00AA1234.
- Errors:
  - word read at 0x02 -> hready=0,hresp=1 then hready=1,hresp=1;
  - read at 4*MEM_DEPTH -> same;
  - neither touches RAM.
- WAIT_STATES=2: word write 0x40 -> exactly 2 cycles hready=0 before completion; readback correct.
- With AHB_SLV_RO_REGION_EN: write 0x55 to word 0xC0 (MEM_DEPTH=256, word 192) -> ERROR; read returns prior value. Without the macro -> OKAY and readback 0x55.
